alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 172 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared ALU. It grants one request at a time,
// registers the operands, waits LATENCY cycles, and stores the result per port.
module alu_arbiter #(
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_rs1,
  input  logic [31:0] req0_op2,
  input  logic [2:0]  req0_op,
  input  logic        req0_mod,
  input  logic        req0_neg,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_rs1,
  input  logic [31:0] req1_op2,
  input  logic [2:0]  req1_op,
  input  logic        req1_mod,
  input  logic        req1_neg,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_mod,
  output logic        alu_neg,
  input  logic [31:0] alu_res,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_data,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_data,
  input  logic        rsp1_ready,
  output logic        busy
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [2:0]  alu_op_q, alu_op_d;
  logic        alu_mod_q, alu_mod_d;
  logic        alu_neg_q, alu_neg_d;
  logic        rsp0_valid_q, rsp0_valid_d;
  logic        rsp1_valid_q, rsp1_valid_d;
  logic [31:0] rsp0_data_q, rsp0_data_d;
  logic [31:0] rsp1_data_q, rsp1_data_d;

  logic elig0, elig1;
  logic gnt0, gnt1;
  logic grant;
  logic done;

  // A port may be granted while its buffer drains, since completion is at least two edges away.
  always_comb begin
    elig0 = req0_valid && (!rsp0_valid_q || rsp0_ready);
    elig1 = req1_valid && (!rsp1_valid_q || rsp1_ready);
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    if (state_q == IDLE && !reset) begin
      if (elig0 && elig1) begin
        gnt0 = last_grant_q;
        gnt1 = !last_grant_q;
      end else begin
        gnt0 = elig0;
        gnt1 = elig1;
      end
    end
    grant = gnt0 || gnt1;
    done  = (state_q == WAIT) && (cnt_q == 3'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = WAIT;
      WAIT:    if (done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = gnt0;
    req1_ready = gnt1;
    busy       = (state_q == WAIT);
    alu_a      = alu_a_q;
    alu_b      = alu_b_q;
    alu_op     = alu_op_q;
    alu_mod    = alu_mod_q;
    alu_neg    = alu_neg_q;
    rsp0_valid = rsp0_valid_q;
    rsp1_valid = rsp1_valid_q;
    rsp0_data  = rsp0_data_q;
    rsp1_data  = rsp1_data_q;
  end

  always_comb begin
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    alu_mod_d    = alu_mod_q;
    alu_neg_d    = alu_neg_q;
    rsp0_valid_d = rsp0_valid_q && !rsp0_ready;
    rsp1_valid_d = rsp1_valid_q && !rsp1_ready;
    rsp0_data_d  = rsp0_data_q;
    rsp1_data_d  = rsp1_data_q;
    if (grant) begin
      owner_d      = gnt1;
      last_grant_d = gnt1;
      cnt_d        = 3'(LATENCY);
      alu_a_d      = gnt1 ? req1_rs1 : req0_rs1;
      alu_b_d      = gnt1 ? req1_op2 : req0_op2;
      alu_op_d     = gnt1 ? req1_op  : req0_op;
      alu_mod_d    = gnt1 ? req1_mod : req0_mod;
      alu_neg_d    = gnt1 ? req1_neg : req0_neg;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q - 3'd1;
    end
    if (done) begin
      if (owner_q) begin
        rsp1_valid_d = 1'b1;
        rsp1_data_d  = alu_res;
      end else begin
        rsp0_valid_d = 1'b1;
        rsp0_data_d  = alu_res;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      alu_mod_q    <= 1'b0;
      alu_neg_q    <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      alu_mod_q    <= alu_mod_d;
      alu_neg_q    <= alu_neg_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a LATENCY=1 instance and a LATENCY=3 instance, each
// driving a small combinational ALU model; grants and responses go through queues.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req0_valid, req0_ready, req0_mod, req0_neg;
  logic        req1_valid, req1_ready, req1_mod, req1_neg;
  logic [31:0] req0_rs1, req0_op2, req1_rs1, req1_op2;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [2:0]  alu_op;
  logic        alu_mod, alu_neg;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready, busy;
  logic [31:0] rsp0_data, rsp1_data;

  logic        d3_req0_valid, d3_req0_ready, d3_req1_valid, d3_req1_ready;
  logic [31:0] d3_req1_rs1, d3_req1_op2;
  logic [2:0]  d3_req1_op;
  logic [31:0] d3_alu_a, d3_alu_b, d3_alu_res;
  logic [2:0]  d3_alu_op;
  logic        d3_alu_mod, d3_alu_neg;
  logic        d3_rsp0_valid, d3_rsp1_valid, d3_rsp1_ready, d3_busy;
  logic [31:0] d3_rsp0_data, d3_rsp1_data;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op, input logic neg);
    case (op)
      3'd0:    return neg ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd4:    return a ^ b;
      3'd6:    return a | b;
      3'd7:    return a & b;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_res    = alu_f(alu_a, alu_b, alu_op, alu_neg);
  assign d3_alu_res = alu_f(d3_alu_a, d3_alu_b, d3_alu_op, d3_alu_neg);

  alu_arbiter #(.LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rs1(req0_rs1),
    .req0_op2(req0_op2), .req0_op(req0_op), .req0_mod(req0_mod), .req0_neg(req0_neg),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rs1(req1_rs1),
    .req1_op2(req1_op2), .req1_op(req1_op), .req1_mod(req1_mod), .req1_neg(req1_neg),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_mod(alu_mod), .alu_neg(alu_neg),
    .alu_res(alu_res),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
    .busy(busy)
  );

  alu_arbiter #(.LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .req0_valid(d3_req0_valid), .req0_ready(d3_req0_ready), .req0_rs1(32'd0),
    .req0_op2(32'd0), .req0_op(3'd0), .req0_mod(1'b0), .req0_neg(1'b0),
    .req1_valid(d3_req1_valid), .req1_ready(d3_req1_ready), .req1_rs1(d3_req1_rs1),
    .req1_op2(d3_req1_op2), .req1_op(d3_req1_op), .req1_mod(1'b0), .req1_neg(1'b0),
    .alu_a(d3_alu_a), .alu_b(d3_alu_b), .alu_op(d3_alu_op), .alu_mod(d3_alu_mod),
    .alu_neg(d3_alu_neg), .alu_res(d3_alu_res),
    .rsp0_valid(d3_rsp0_valid), .rsp0_data(d3_rsp0_data), .rsp0_ready(1'b1),
    .rsp1_valid(d3_rsp1_valid), .rsp1_data(d3_rsp1_data), .rsp1_ready(d3_rsp1_ready),
    .busy(d3_busy)
  );

  int total = 0;
  int bad   = 0;
  int gq[$];
  logic [31:0] q0[$], q1[$], q3[$];
  logic [9:0] exp_r0, exp_r1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #3;
  endtask

  // Monitor: every grant and every consumed response is matched against the queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (req0_ready || req1_ready) begin
        if (gq.size() == 0) chk("grant_unexpected", {30'd0, req1_ready, req0_ready}, 32'd0);
        else chk("grant", {30'd0, req1_ready, req0_ready}, 32'd1 << gq.pop_front());
      end
      if (rsp0_valid && rsp0_ready) begin
        if (q0.size() == 0) chk("rsp0_unexpected", rsp0_data, 32'hxxxx_xxxx);
        else chk("rsp0_data", rsp0_data, q0.pop_front());
      end
      if (rsp1_valid && rsp1_ready) begin
        if (q1.size() == 0) chk("rsp1_unexpected", rsp1_data, 32'hxxxx_xxxx);
        else chk("rsp1_data", rsp1_data, q1.pop_front());
      end
      if (d3_rsp1_valid && d3_rsp1_ready) begin
        if (q3.size() == 0) chk("d3_rsp1_unexpected", d3_rsp1_data, 32'hxxxx_xxxx);
        else chk("d3_rsp1_data", d3_rsp1_data, q3.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    req0_valid = 1'b1; req0_rs1 = 32'd1; req0_op2 = 32'd1; req0_op = 3'd0;
    req0_mod = 1'b0; req0_neg = 1'b0;
    req1_valid = 1'b0; req1_rs1 = '0; req1_op2 = '0; req1_op = 3'd0;
    req1_mod = 1'b0; req1_neg = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    d3_req0_valid = 1'b0; d3_req1_valid = 1'b0;
    d3_req1_rs1 = '0; d3_req1_op2 = '0; d3_req1_op = 3'd0; d3_rsp1_ready = 1'b1;
    tick; tick; settle;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_data", rsp1_data, 0);
    tick;
    req0_valid = 1'b0; reset = 1'b0;
    tick;

    // Single ADD on port 0 with the shift modifier set.
    req0_valid = 1'b1; req0_rs1 = 32'd5; req0_op2 = 32'd7; req0_op = 3'd0; req0_mod = 1'b1;
    gq.push_back(0); q0.push_back(32'd12);
    settle; chk("a_req0_ready_c0", req0_ready, 1);
    tick; req0_valid = 1'b0; settle;
    chk("a_busy_c1", busy, 1);
    chk("a_req0_ready_c1", req0_ready, 0);
    chk("a_alu_a", alu_a, 32'd5);
    chk("a_alu_b", alu_b, 32'd7);
    chk("a_alu_mod", alu_mod, 1);
    tick; settle;
    chk("a_rsp0_valid_c2", rsp0_valid, 1);
    chk("a_rsp0_data_c2", rsp0_data, 32'd12);
    chk("a_busy_c2", busy, 0);
    tick; settle;
    chk("a_rsp0_valid_c3", rsp0_valid, 0);
    req0_mod = 1'b0;
    tick;

    // Both ports requesting continuously after reset: alternate 0,1,0,1.
    reset = 1'b1; tick; reset = 1'b0;
    req0_valid = 1'b1; req0_rs1 = 32'd10; req0_op2 = 32'd3; req0_op = 3'd0; req0_neg = 1'b1;
    req1_valid = 1'b1; req1_rs1 = 32'hF0; req1_op2 = 32'h0F; req1_op = 3'd6;
    gq.push_back(0); gq.push_back(1); gq.push_back(0); gq.push_back(1);
    q0.push_back(32'd7); q0.push_back(32'd7); q1.push_back(32'hFF); q1.push_back(32'hFF);
    for (int i = 0; i < 8; i++) begin
      settle;
      chk("b_req0_ready", req0_ready, 32'(i % 4 == 0));
      chk("b_req1_ready", req1_ready, 32'(i % 4 == 2));
      if (i == 1) chk("b_alu_neg", alu_neg, 1);
      tick;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; req0_neg = 1'b0;
    tick; tick;

    // Port 1 result left unconsumed blocks port 1 until rsp1_ready rises.
    rsp1_ready = 1'b0;
    req1_valid = 1'b1; req1_rs1 = 32'h1; req1_op2 = 32'd4; req1_op = 3'd1;
    req0_rs1 = 32'h100; req0_op2 = 32'h0FF; req0_op = 3'd4;
    gq.push_back(1); gq.push_back(0); gq.push_back(0); gq.push_back(0); gq.push_back(1);
    q1.push_back(32'h10); q1.push_back(32'h10);
    q0.push_back(32'h1FF); q0.push_back(32'h1FF); q0.push_back(32'h1FF);
    exp_r0 = 10'b00_0101_0100;
    exp_r1 = 10'b01_0000_0001;
    for (int i = 0; i < 10; i++) begin
      if (i == 1) req0_valid = 1'b1;
      if (i == 8) rsp1_ready = 1'b1;
      settle;
      chk("c_req0_ready", req0_ready, 32'(exp_r0[i]));
      chk("c_req1_ready", req1_ready, 32'(exp_r1[i]));
      if (i >= 2 && i <= 7) begin
        chk("c_rsp1_hold_valid", rsp1_valid, 1);
        chk("c_rsp1_hold_data", rsp1_data, 32'h10);
      end
      tick;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick; tick; tick;

    // Port 0 result held for five cycles while port 1 completes an operation.
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_rs1 = 32'hDEAD_0000; req0_op2 = 32'h0000_BEEF; req0_op = 3'd6;
    gq.push_back(0); q0.push_back(32'hDEAD_BEEF);
    for (int i = 0; i < 9; i++) begin
      if (i == 1) req0_valid = 1'b0;
      if (i == 2) begin
        req1_valid = 1'b1; req1_rs1 = 32'd3; req1_op2 = 32'd4; req1_op = 3'd0;
        gq.push_back(1); q1.push_back(32'd7);
      end
      if (i == 3) req1_valid = 1'b0;
      if (i == 7) rsp0_ready = 1'b1;
      settle;
      if (i == 0) chk("d_req0_ready", req0_ready, 1);
      if (i >= 2 && i <= 6) begin
        chk("d_rsp0_hold_valid", rsp0_valid, 1);
        chk("d_rsp0_hold_data", rsp0_data, 32'hDEAD_BEEF);
      end
      if (i == 4) chk("d_rsp1_valid", rsp1_valid, 1);
      if (i == 8) chk("d_rsp0_cleared", rsp0_valid, 0);
      tick;
    end

    // Reset the cycle after a grant abandons the operation.
    req0_valid = 1'b1; req0_rs1 = 32'd1; req0_op2 = 32'd1; req0_op = 3'd0;
    gq.push_back(0);
    settle; chk("e_req0_ready", req0_ready, 1);
    tick; req0_valid = 1'b0; settle;
    chk("e_busy_before_reset", busy, 1);
    reset = 1'b1;
    tick; reset = 1'b0; settle;
    chk("e_busy_after_reset", busy, 0);
    for (int i = 0; i < 4; i++) begin
      chk("e_no_rsp0", rsp0_valid, 0);
      tick; settle;
    end
    tick;
    req0_valid = 1'b1; req0_rs1 = 32'd2; req0_op2 = 32'd3; req0_op = 3'd7;
    req1_valid = 1'b1; req1_rs1 = 32'd9; req1_op2 = 32'd1; req1_op = 3'd0; req1_neg = 1'b1;
    gq.push_back(0); gq.push_back(1); q0.push_back(32'd2); q1.push_back(32'd8);
    settle;
    chk("e_tie_req0_ready", req0_ready, 1);
    chk("e_tie_req1_ready", req1_ready, 0);
    tick; tick; settle;
    chk("e_second_req1_ready", req1_ready, 1);
    tick; req0_valid = 1'b0; req1_valid = 1'b0; req1_neg = 1'b0;
    tick; tick; tick;

    // LATENCY=3 instance: result four cycles after acceptance, no grant during WAIT.
    d3_req1_valid = 1'b1; d3_req1_rs1 = 32'h1234; d3_req1_op2 = 32'd1; d3_req1_op = 3'd0;
    q3.push_back(32'h1235);
    settle; chk("f_req1_ready_c0", d3_req1_ready, 1);
    tick;
    d3_req0_valid = 1'b1;
    for (int i = 1; i < 4; i++) begin
      settle;
      chk("f_req0_ready_wait", d3_req0_ready, 0);
      chk("f_req1_ready_wait", d3_req1_ready, 0);
      chk("f_busy_wait", d3_busy, 1);
      chk("f_rsp1_valid_wait", d3_rsp1_valid, 0);
      tick;
    end
    d3_req0_valid = 1'b0; d3_req1_valid = 1'b0;
    settle;
    chk("f_rsp1_valid_c4", d3_rsp1_valid, 1);
    chk("f_rsp1_data_c4", d3_rsp1_data, 32'h1235);
    chk("f_rsp0_untouched", d3_rsp0_valid, 0);
    tick; settle;
    chk("f_rsp1_valid_c5", d3_rsp1_valid, 0);
    tick; tick;

    chk("end_grant_queue", gq.size(), 0);
    chk("end_rsp0_queue", q0.size(), 0);
    chk("end_rsp1_queue", q1.size(), 0);
    chk("end_d3_queue", q3.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
